router_arbiter: RTL and testbench

ROUTER_ARBITER -- requirements
Module: router_arbiter

---
 rtl/router_arbiter_if.sv | 22 ++
 rtl/router_arbiter.sv | 100 ++++++++++
 tb/tb_router_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/router_arbiter_if.sv
// Handshake bundle between the 4x4 serial router and its ports.
// Requests, frames and data come in; grants, frames and data go out.
interface router_arbiter_if #(
  parameter int N = 4
);
  logic [N*N-1:0] i_req;
  logic [N-1:0]   i_frame;
  logic [N-1:0]   i_data;
  logic [N-1:0]   o_gnt;
  logic [N-1:0]   o_frame;
  logic [N-1:0]   o_data;

  modport master (
    output i_req, i_frame, i_data,
    input  o_gnt, o_frame, o_data
  );

  modport slave (
    input  i_req, i_frame, i_data,
    output o_gnt, o_frame, o_data
  );
endinterface

// File: rtl/router_arbiter.sv
// 4x4 serial crossbar: one round-robin arbiter per output port, each owning
// a single input for the length of its frame.
module router_arbiter #(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  router_arbiter_if.slave     bus
);
  typedef enum logic {IDLE, BUSY} state_e;

  logic [N-1:0]   nib_ok;
  logic [N-1:0]   busy_nx;
  logic [2*N-1:0] owner_nx;
  logic [N-1:0]   gnt_d;
  logic [N-1:0]   gnt_q;

  // A request nibble naming several outputs is ignored entirely.
  for (genvar gi = 0; gi < N; gi++) begin : g_nib
    logic [3:0] nib;
    assign nib        = bus.i_req[4*gi +: 4];
    assign nib_ok[gi] = ((nib & (nib - 4'd1)) == 4'd0);
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_arb
    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel, idx;
    logic       found;
    logic       frame_q, data_q;
    logic [N-1:0] cand;

    for (genvar gk = 0; gk < N; gk++) begin : g_cand
      assign cand[gk] = bus.i_req[4*gk + gi] & nib_ok[gk];
    end

    always_comb begin
      found   = 1'b0;
      sel     = ptr_q;
      idx     = ptr_q;
      for (int k = 0; k < N; k++) begin
        idx = ptr_q + 2'(k);
        if (!found && cand[idx]) begin
          found = 1'b1;
          sel   = idx;
        end
      end
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      if (state_q == IDLE) begin
        if (found) begin
          state_d = BUSY;
          owner_d = sel;
          ptr_d   = sel + 2'd1;
        end
      end else if (!bus.i_frame[owner_q]) begin
        // Release takes the whole edge; regrant waits for the next IDLE cycle.
        state_d = IDLE;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        owner_q <= 2'd0;
        ptr_q   <= 2'd0;
        frame_q <= 1'b0;
        data_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
        ptr_q   <= ptr_d;
        frame_q <= (state_q == BUSY) ? bus.i_frame[owner_q] : 1'b0;
        data_q  <= (state_q == BUSY) ? bus.i_data[owner_q]  : 1'b0;
      end
    end

    assign busy_nx[gi]          = (state_d == BUSY);
    assign owner_nx[2*gi +: 2]  = owner_d;
    assign bus.o_frame[gi]      = frame_q;
    assign bus.o_data[gi]       = data_q;
  end

  // Grants are decoded from next state so they appear with the new ownership.
  always_comb begin
    gnt_d = '0;
    for (int j = 0; j < N; j++) begin
      if (busy_nx[j]) gnt_d[owner_nx[2*j +: 2]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) gnt_q <= '0;
    else          gnt_q <= gnt_d;
  end

  assign bus.o_gnt = gnt_q;
endmodule

// File: tb/tb_router_arbiter.sv
// Directed bench for router_arbiter: single transfer, contention, fairness,
// parallel grants, invalid request nibble and asynchronous reset mid-frame.
module tb_router_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  router_arbiter_if #(.N(4)) bus ();

  router_arbiter #(.N(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end else begin
      $display("ok   %s: %h", tag, act);
    end
  endtask

  // Drive inputs, let one rising edge sample them, settle 1 time unit.
  task automatic step(input logic [15:0] req, input logic [3:0] frame, input logic [3:0] data);
    bus.i_req   = req;
    bus.i_frame = frame;
    bus.i_data  = data;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_req   = '0;
    bus.i_frame = '0;
    bus.i_data  = '0;
    reset_n     = 1'b0;
    @(posedge clk);
    #1;
    reset_n     = 1'b1;
  endtask

  initial begin
    bus.i_req   = '0;
    bus.i_frame = '0;
    bus.i_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_gnt",   16'(bus.o_gnt),   16'h0);
    check_eq("reset_frame", 16'(bus.o_frame), 16'h0);
    check_eq("reset_data",  16'(bus.o_data),  16'h0);
    reset_n = 1'b1;

    // Single request: input 0 -> output 2
    step(16'h0004, 4'b0001, 4'b0001);
    check_eq("single_gnt", 16'(bus.o_gnt), 16'h1);
    step(16'h0004, 4'b0001, 4'b0000);
    check_eq("single_frame", 16'(bus.o_frame), 16'h4);
    check_eq("single_data0", 16'(bus.o_data),  16'h0);
    step(16'h0004, 4'b0001, 4'b0001);
    check_eq("single_data1", 16'(bus.o_data),  16'h4);
    step(16'h0000, 4'b0000, 4'b0000);
    check_eq("single_rel_gnt",   16'(bus.o_gnt),   16'h0);
    check_eq("single_rel_frame", 16'(bus.o_frame), 16'h0);

    // Contention: inputs 1 and 3 -> output 0
    do_reset();
    step(16'h1010, 4'b1010, 4'b0000);
    check_eq("cont_first", 16'(bus.o_gnt), 16'h2);
    step(16'h1010, 4'b1000, 4'b0000);
    check_eq("cont_idle", 16'(bus.o_gnt), 16'h0);
    step(16'h1010, 4'b1010, 4'b0000);
    check_eq("cont_second", 16'(bus.o_gnt), 16'h8);
    step(16'h1010, 4'b0010, 4'b0000);
    check_eq("cont_idle2", 16'(bus.o_gnt), 16'h0);
    step(16'h1010, 4'b1010, 4'b0000);
    check_eq("cont_wrap", 16'(bus.o_gnt), 16'h2);
    step(16'h0000, 4'b0000, 4'b0000);

    // Fairness: all inputs -> output 1, 3-cycle frames
    do_reset();
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        logic [3:0] g;
        g = 4'b0001 << order[k];
        step(16'h2222, 4'b1111, 4'b0000);
        check_eq($sformatf("rr_grant%0d", k), 16'(bus.o_gnt), 16'(g));
        step(16'h2222, 4'b1111, 4'b0000);
        step(16'h2222, 4'b1111, 4'b0000);
        check_eq($sformatf("rr_hold%0d", k), 16'(bus.o_gnt), 16'(g));
        step(16'h2222, 4'b1111 & ~g, 4'b0000);
        check_eq($sformatf("rr_idle%0d", k), 16'(bus.o_gnt), 16'h0);
      end
    end
    step(16'h0000, 4'b0000, 4'b0000);

    // Parallel: input 0 -> output 3, input 2 -> output 1
    do_reset();
    step(16'h0208, 4'b0101, 4'b0001);
    check_eq("par_gnt", 16'(bus.o_gnt), 16'h5);
    step(16'h0208, 4'b0101, 4'b0001);
    check_eq("par_frame", 16'(bus.o_frame), 16'hA);
    check_eq("par_data_a", 16'(bus.o_data), 16'h8);
    step(16'h0208, 4'b0101, 4'b0100);
    check_eq("par_data_b", 16'(bus.o_data), 16'h2);
    step(16'h0000, 4'b0000, 4'b0000);
    check_eq("par_rel", 16'(bus.o_gnt), 16'h0);

    // Invalid nibble on input 1, input 0 -> output 2 still served
    do_reset();
    step(16'h0034, 4'b0011, 4'b0000);
    check_eq("inv_gnt", 16'(bus.o_gnt), 16'h1);
    step(16'h0034, 4'b0011, 4'b0000);
    check_eq("inv_frame", 16'(bus.o_frame), 16'h4);
    step(16'h0030, 4'b0010, 4'b0000);
    check_eq("inv_rel", 16'(bus.o_gnt), 16'h0);
    step(16'h0030, 4'b0010, 4'b0000);
    check_eq("inv_never", 16'(bus.o_gnt), 16'h0);
    step(16'h0000, 4'b0000, 4'b0000);

    // Asynchronous reset while input 2 owns output 0
    do_reset();
    step(16'h0100, 4'b0100, 4'b0100);
    check_eq("rst_pre_gnt", 16'(bus.o_gnt), 16'h4);
    step(16'h0100, 4'b0100, 4'b0100);
    check_eq("rst_pre_frame", 16'(bus.o_frame), 16'h1);
    check_eq("rst_pre_data",  16'(bus.o_data),  16'h1);
    reset_n = 1'b0;
    #2;
    check_eq("rst_async_gnt",   16'(bus.o_gnt),   16'h0);
    check_eq("rst_async_frame", 16'(bus.o_frame), 16'h0);
    check_eq("rst_async_data",  16'(bus.o_data),  16'h0);
    reset_n = 1'b1;
    step(16'h0100, 4'b0100, 4'b0100);
    check_eq("rst_regrant", 16'(bus.o_gnt), 16'h4);
    check_eq("rst_regrant_frame", 16'(bus.o_frame), 16'h0);
    step(16'h0000, 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
